// File: rtl/fpu_exp_sub_if.sv
// Handshake and data bundle for the double-precision exponent-difference stage.
// master drives operands and consumes results; slave is the stage itself.
interface fpu_exp_sub_if;
  logic        in_valid;
  logic [10:0] ea;
  logic [10:0] eb;
  logic        out_valid;
  logic        eb_gt_ea;
  logic [10:0] as;
  logic [5:0]  as_sat;

  modport master (
    output in_valid,
    output ea,
    output eb,
    input  out_valid,
    input  eb_gt_ea,
    input  as,
    input  as_sat
  );

  modport slave (
    input  in_valid,
    input  ea,
    input  eb,
    output out_valid,
    output eb_gt_ea,
    output as,
    output as_sat
  );
endinterface

// File: rtl/fpu_exp_sub.sv
// Registered exponent-difference stage: larger-exponent select, |ea - eb| and a
// 6-bit saturated alignment shift distance, with one cycle of latency.
module fpu_exp_sub (
  input  logic         clk,
  input  logic         rst,
  fpu_exp_sub_if.slave bus
);

  logic [11:0] diff;
  logic        borrow;
  logic [10:0] mag;
  logic [5:0]  sat;

  logic        valid_d, valid_q;
  logic        gt_d, gt_q;
  logic [10:0] as_d, as_q;
  logic [5:0]  sat_d, sat_q;

  // Single subtractor; the borrow flags eb > ea and selects a two's-complement negate.
  always_comb begin
    diff   = {1'b0, bus.ea} - {1'b0, bus.eb};
    borrow = diff[11];
    mag    = borrow ? (~diff[10:0] + 11'd1) : diff[10:0];
    sat    = (mag[10:6] != 5'd0) ? 6'd63 : mag[5:0];
  end

  // Data registers hold when idle; consumers qualify them with out_valid.
  always_comb begin
    valid_d = bus.in_valid;
    gt_d    = gt_q;
    as_d    = as_q;
    sat_d   = sat_q;
    if (bus.in_valid) begin
      gt_d  = borrow;
      as_d  = mag;
      sat_d = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      as_q    <= 11'd0;
      sat_q   <= 6'd0;
    end else begin
      valid_q <= valid_d;
      gt_q    <= gt_d;
      as_q    <= as_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.eb_gt_ea  = gt_q;
  assign bus.as        = as_q;
  assign bus.as_sat    = sat_q;

endmodule

// File: tb/tb_fpu_exp_sub.sv
// Bench for fpu_exp_sub: directed cases against fixed expectations plus a
// queue-based scoreboard fed by an independent reference model.
module tb_fpu_exp_sub;

  typedef struct packed {
    logic        g;
    logic [10:0] a;
    logic [5:0]  s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpu_exp_sub_if bus ();

  fpu_exp_sub dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t held = '0;
  logic exp_ov = 1'b0;

  function automatic exp_t ref_model(input logic [10:0] a, input logic [10:0] b);
    exp_t        r;
    int unsigned m;
    r.g = (b > a);
    m   = r.g ? (int'(b) - int'(a)) : (int'(a) - int'(b));
    r.a = m[10:0];
    r.s = (m > 63) ? 6'd63 : m[5:0];
    return r;
  endfunction

  // Drive one cycle, push the model result, then update the expected output state
  // from the scoreboard once the edge has passed.
  task automatic step(input logic r, input logic v, input logic [10:0] a, input logic [10:0] b);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.ea       = a;
    bus.eb       = b;
    if (v && !r) sb.push_back(ref_model(a, b));
    @(posedge clk);
    #1;
    if (r) begin
      exp_ov = 1'b0;
      held   = '0;
      sb.delete();
    end else if (v) begin
      exp_ov = 1'b1;
      if (sb.size() != 0) held = sb.pop_front();
    end else begin
      exp_ov = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 11'd5, 11'd9);
      n_cmp++;
      if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== 19'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h want %h", i,
                 {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat}, 19'd0);
      end
    end
  endtask

  task automatic test_directed();
    logic [10:0] ta[8];
    logic [10:0] tb[8];
    logic [18:0] te[8];
    ta = '{11'd1, 11'd292, 11'd1024, 11'd682, 11'd2047, 11'd2, 11'd1000, 11'd1000};
    tb = '{11'd1, 11'd292, 11'd512, 11'd1365, 11'd0, 11'd1, 11'd1063, 11'd1062};
    te = '{{1'b1, 1'b0, 11'd0, 6'd0},   {1'b1, 1'b0, 11'd0, 6'd0},
           {1'b1, 1'b0, 11'd512, 6'd63}, {1'b1, 1'b1, 11'd683, 6'd63},
           {1'b1, 1'b0, 11'd2047, 6'd63}, {1'b1, 1'b0, 11'd1, 6'd1},
           {1'b1, 1'b1, 11'd63, 6'd63},  {1'b1, 1'b1, 11'd62, 6'd62}};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, ta[i], tb[i]);
      n_cmp++;
      if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== te[i]) begin
        n_err++;
        $display("FAIL directed ea=%0d eb=%0d: got %h want %h", ta[i], tb[i],
                 {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat}, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] sa[5];
    logic [10:0] sb_[5];
    logic        sv[5];
    sa  = '{11'd100, 11'd7, 11'd1500, 11'd0, 11'd0};
    sb_ = '{11'd40, 11'd300, 11'd1490, 11'd0, 11'd0};
    sv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, sv[i], sa[i], sb_[i]);
      n_cmp++;
      if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== {exp_ov, held}) begin
        n_err++;
        $display("FAIL stream[%0d]: got %h want %h", i,
                 {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat}, {exp_ov, held});
      end
    end
    // Third result (1500 vs 1490) must still be held after the idle cycles.
    n_cmp++;
    if ({bus.eb_gt_ea, bus.as, bus.as_sat} !== {1'b0, 11'd10, 6'd10}) begin
      n_err++;
      $display("FAIL hold: got %h want %h", {bus.eb_gt_ea, bus.as, bus.as_sat},
               {1'b0, 11'd10, 6'd10});
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, 11'd3, 11'd900);
    n_cmp++;
    if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== {1'b1, 1'b1, 11'd897, 6'd63}) begin
      n_err++;
      $display("FAIL pre_reset: got %h want %h", {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat},
               {1'b1, 1'b1, 11'd897, 6'd63});
    end
    step(1'b1, 1'b1, 11'd50, 11'd10);
    n_cmp++;
    if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== 19'd0) begin
      n_err++;
      $display("FAIL mid_reset: got %h want %h",
               {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat}, 19'd0);
    end
    step(1'b0, 1'b1, 11'd50, 11'd10);
    n_cmp++;
    if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== {1'b1, 1'b0, 11'd40, 6'd40}) begin
      n_err++;
      $display("FAIL post_reset: got %h want %h", {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat},
               {1'b1, 1'b0, 11'd40, 6'd40});
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        v;
    logic [10:0] a;
    logic [10:0] b;
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = 1'($urandom_range(0, 1));
      a = 11'($urandom_range(0, 2047));
      // Bias some operands close together to exercise the saturation edge.
      b = ($urandom_range(0, 3) == 0) ? 11'(a + 11'($urandom_range(0, 130)) - 11'd65)
                                     : 11'($urandom_range(0, 2047));
      step(r, v, a, b);
      n_cmp++;
      if ({bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat} !== {exp_ov, held}) begin
        n_err++;
        $display("FAIL random[%0d] ea=%0d eb=%0d: got %h want %h", i, a, b,
                 {bus.out_valid, bus.eb_gt_ea, bus.as, bus.as_sat}, {exp_ov, held});
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.ea       = '0;
    bus.eb       = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_exp_sub.md
# fpu_exp_sub

Registered exponent-difference stage of the floating-point adder for IEEE-754 double precision. It takes the two 11-bit biased exponents, decides which exponent is larger, and produces the magnitude of their difference as the significand alignment shift distance. It also produces a saturated 6-bit copy of that distance for the alignment shifter. It sits between operand unpacking and the alignment shifter, and all outputs are registered with a valid flag.

## Interface
- No parameters; exponent width is fixed at 11 bits (double precision).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ea/eb are valid this cycle.
- ea  in  11  biased exponent of operand A (unsigned).
- eb  in  11  biased exponent of operand B (unsigned).
- out_valid  out  1  registered; high one cycle after an accepted in_valid.
- eb_gt_ea  out  1  registered; 1 iff eb > ea (strict, unsigned).
- as  out  11  registered; |ea − eb| (unsigned).
- as_sat  out  6  registered; min(|ea − eb|, 63), the shifter distance.

## Operation
- Compute the full 12-bit difference d = {1'b0,ea} − {1'b0,eb}.
- The borrow (bit 11 of d) is eb_gt_ea.
- If eb_gt_ea = 1, as = eb − ea; otherwise as = ea − eb.
  - Implement with a single subtractor plus a conditional two's-complement negate, or with two subtractors and a mux.
- The result is exact. The maximum magnitude is 2047, so there is no overflow in 11 bits.
- Equal exponents give eb_gt_ea = 0 and as = 0 (A is treated as the larger operand on ties).
- as_sat = as[5:0] when as[10:6] == 0; otherwise as_sat = 6'd63.
  - Any distance ≥ 63 exceeds the 53-bit significand plus guard/round bits, so the whole operand collapses into sticky.
- Purely unsigned arithmetic. Exponent values 0 (denormal/zero) and 2047 (Inf/NaN) get no special treatment; special-case handling lives downstream.

## Timing
- Latency is exactly 1 cycle: inputs sampled at a rising edge appear on the outputs after that edge. Throughput is one operation per cycle.
- There is no backpressure.
- Reset (rst = 1 at a rising edge) has priority over everything else. After that edge: out_valid = 0, eb_gt_ea = 0, as = 0, as_sat = 0.
- If rst and in_valid are asserted in the same cycle, the input is discarded.
- When in_valid = 1 and rst = 0, all data registers load and out_valid is set to 1 at the next edge.
- When in_valid = 0 and rst = 0:
  - out_valid goes to 0 at the next edge.
  - eb_gt_ea, as and as_sat hold their last values. Consumers must qualify them with out_valid.
- Back-to-back valid inputs produce back-to-back valid outputs, each reflecting its own inputs. No stage mixes fields from different operations.
- Reset asserted mid-stream clears out_valid on the same edge. The first valid output after rst deasserts is the one for the first in_valid sampled with rst = 0.

## Test plan
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, ea = 5, eb = 9 → out_valid = 0, eb_gt_ea = 0, as = 0, as_sat = 0 throughout.
- Equal exponents: ea = 1, eb = 1, in_valid = 1 → one cycle later out_valid = 1, eb_gt_ea = 0, as = 0, as_sat = 0. Also ea = eb = 292 gives the same result.
- Ordering, one case per direction:
  - ea = 1024, eb = 512 → eb_gt_ea = 0, as = 512, as_sat = 63.
  - ea = 682, eb = 1365 → eb_gt_ea = 1, as = 683, as_sat = 63.
- Extremes and small distances:
  - ea = 2047, eb = 0 → eb_gt_ea = 0, as = 2047, as_sat = 63.
  - ea = 2, eb = 1 → eb_gt_ea = 0, as = 1, as_sat = 1.
  - ea = 1000, eb = 1063 → eb_gt_ea = 1, as = 63, as_sat = 63.
  - ea = 1000, eb = 1062 → eb_gt_ea = 1, as = 62, as_sat = 62.
- Streaming and hold:
  - Drive 3 back-to-back valid pairs, then in_valid = 0 for 2 cycles → 3 consecutive correct valid outputs, then out_valid = 0 with the data outputs holding the third result.
  - Assert rst in the middle of the stream → out_valid = 0 on the following edge and data outputs = 0.
- Randomized: 10k random ea/eb pairs with random in_valid, checked against a 1-cycle-delayed reference model of eb_gt_ea, as and as_sat.
